// File: rtl/vga_axi_mem_ctrl_if.sv
// AXI4-Lite read-address and read-data channels between the frame fetcher and the interconnect.
// Latency: none, wires only.
// Backpressure: the standard valid/ready pairing on AR and R.
interface vga_axi_mem_ctrl_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WITH  = 64
);
    logic [AXI_ADDR_WIDTH-1:0] m_araddr_o;
    logic [2:0]                m_arprot_o;
    logic                      m_arvalid_o;
    logic                      m_arrdy_i;
    logic [AXI_DATA_WITH-1:0]  m_rdata_i;
    logic                      m_rvalid_i;
    logic                      m_rrdy_o;
    logic [1:0]                m_rresp_i;

    modport master (
        output m_araddr_o, m_arprot_o, m_arvalid_o, m_rrdy_o,
        input  m_arrdy_i, m_rdata_i, m_rvalid_i, m_rresp_i
    );

    modport slave (
        input  m_araddr_o, m_arprot_o, m_arvalid_o, m_rrdy_o,
        output m_arrdy_i, m_rdata_i, m_rvalid_i, m_rresp_i
    );
endinterface

// File: rtl/vga_axi_mem_ctrl.sv
// Fetches frame-buffer words over AXI4-Lite for the VGA pixel path, one AR/R pair per new word.
// Latency: 3 cycles from address trigger in IDLE to the pixel data strobe with a zero-wait slave.
// Backpressure: AR is held stable until arready; rready is held until rvalid; one transaction in flight.
module vga_axi_mem_ctrl #(
    parameter int                      AXI_ADDR_WIDTH = 32,
    parameter int                      AXI_DATA_WITH  = 64,
    parameter int                      PXL_CTR_WIDTH  = 10,
    parameter int                      LINE_CTR_WIDTH = 10,
    parameter int                      H_PIXELS       = 640,
    parameter int                      V_LINES        = 480,
    parameter int                      PXL_BITS       = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PXL_CTR_WIDTH-1:0]  pxl_ctr_i,
    input  logic [LINE_CTR_WIDTH-1:0] line_ctr_i,
    vga_axi_mem_ctrl_if.master        axi,
    output logic [AXI_DATA_WITH-1:0]  pxl_data_o,
    output logic                      pxl_data_valid_o,
    output logic                      rd_err_o
);

    localparam int PPW            = AXI_DATA_WITH / PXL_BITS;
    localparam int WORDS_PER_LINE = H_PIXELS / PPW;
    localparam int BYTES_PER_WORD = AXI_DATA_WITH / 8;
    // Wide enough that line*words_per_line*bytes plus the base can never wrap.
    localparam int PROD_W         = AXI_ADDR_WIDTH + LINE_CTR_WIDTH + PXL_CTR_WIDTH;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t                    state_q, state_nxt;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_nxt;
    logic [AXI_ADDR_WIDTH-1:0] last_addr_q, last_addr_nxt;
    logic                      arvalid_q, arvalid_nxt;
    logic                      rrdy_q, rrdy_nxt;
    logic [AXI_DATA_WITH-1:0]  data_q, data_nxt;
    logic                      data_vld_q, data_vld_nxt;
    logic                      err_q, err_nxt;

    logic [PROD_W-1:0]         word_idx;
    logic [PROD_W-1:0]         addr_full;
    logic [AXI_ADDR_WIDTH-1:0] word_addr;
    logic                      visible;

    // Map the pixel/line counters to the byte address of the word holding that pixel.
    always_comb begin
        word_idx  = PROD_W'(line_ctr_i) * PROD_W'(WORDS_PER_LINE)
                  + PROD_W'(pxl_ctr_i) / PROD_W'(PPW);
        addr_full = PROD_W'(BASE_ADDR) + word_idx * PROD_W'(BYTES_PER_WORD);
        word_addr = addr_full[AXI_ADDR_WIDTH-1:0];
        visible   = (PROD_W'(pxl_ctr_i) < PROD_W'(H_PIXELS))
                 && (PROD_W'(line_ctr_i) < PROD_W'(V_LINES));
    end

    // State register; reset drops any in-flight transaction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and next-output decode for the single-outstanding AR/R sequence.
    always_comb begin
        state_nxt     = state_q;
        araddr_nxt    = araddr_q;
        last_addr_nxt = last_addr_q;
        arvalid_nxt   = arvalid_q;
        rrdy_nxt      = rrdy_q;
        data_nxt      = data_q;
        data_vld_nxt  = 1'b0;
        err_nxt       = err_q;
        case (state_q)
            ST_RESET: begin
                state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (visible && (word_addr != last_addr_q)) begin
                    araddr_nxt    = word_addr;
                    last_addr_nxt = word_addr;
                    arvalid_nxt   = 1'b1;
                    state_nxt     = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // Address is never withdrawn once presented, whatever the counters do.
                if (arvalid_q && axi.m_arrdy_i) begin
                    arvalid_nxt = 1'b0;
                    rrdy_nxt    = 1'b1;
                    state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (axi.m_rvalid_i && rrdy_q) begin
                    data_nxt     = axi.m_rdata_i;
                    data_vld_nxt = 1'b1;
                    rrdy_nxt     = 1'b0;
                    // Error responses are flagged but the data still goes downstream.
                    if (axi.m_rresp_i != 2'b00) begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_RESET;
            end
        endcase
    end

    // Registered bus and pixel-path outputs; last_addr resets to a value no word address can hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            araddr_q    <= '0;
            last_addr_q <= '1;
            arvalid_q   <= 1'b0;
            rrdy_q      <= 1'b0;
            data_q      <= '0;
            data_vld_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            araddr_q    <= araddr_nxt;
            last_addr_q <= last_addr_nxt;
            arvalid_q   <= arvalid_nxt;
            rrdy_q      <= rrdy_nxt;
            data_q      <= data_nxt;
            data_vld_q  <= data_vld_nxt;
            err_q       <= err_nxt;
        end
    end

    assign axi.m_araddr_o  = araddr_q;
    assign axi.m_arprot_o  = 3'b000;
    assign axi.m_arvalid_o = arvalid_q;
    assign axi.m_rrdy_o    = rrdy_q;
    assign pxl_data_o      = data_q;
    assign pxl_data_valid_o = data_vld_q;
    assign rd_err_o        = err_q;

endmodule

// File: tb/tb_vga_axi_mem_ctrl.sv
// Directed bench for the VGA frame fetcher with a scoreboard of expected addresses and data.
// Latency: checks the 3-cycle minimum and the hold behaviour under AR/R wait states.
// Backpressure: slave ready/valid are driven directly from the stimulus sequence.
module tb_vga_axi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pxl;
    logic [9:0]  line;
    logic [63:0] pxl_data;
    logic        pxl_vld;
    logic        rd_err;

    int n_chk  = 0;
    int n_pass = 0;
    int ar_hs  = 0;
    int strobes = 0;

    logic [31:0] addr_q[$];
    logic [63:0] data_q[$];

    vga_axi_mem_ctrl_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WITH(64)) bus ();

    vga_axi_mem_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .pxl_ctr_i        (pxl),
        .line_ctr_i       (line),
        .axi              (bus.master),
        .pxl_data_o       (pxl_data),
        .pxl_data_valid_o (pxl_vld),
        .rd_err_o         (rd_err)
    );

    always #5 clk = ~clk;

    // Count AR handshakes and data strobes as they happen on the bus.
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.m_arvalid_o && bus.m_arrdy_i) ar_hs++;
            if (pxl_vld) strobes++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_addr(input int p, input int l);
        return 32'((l * 160 + p / 4) * 8);
    endfunction

    // One complete fetch with optional AR and R wait states.
    task automatic fetch(input int p, input int l, input logic [63:0] d, input logic [1:0] resp,
                         input int ar_wait, input int r_wait);
        logic [31:0] a;
        int hs0;
        int st0;
        bit seen;
        addr_q.push_back(model_addr(p, l));
        data_q.push_back(d);
        hs0 = ar_hs;
        st0 = strobes;
        bus.m_arrdy_i  = 1'b0;
        bus.m_rvalid_i = 1'b0;
        pxl  = 10'(p);
        line = 10'(l);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = bus.m_arvalid_o;
        end
        if (!seen) begin
            chk("ar_timeout", 64'd0, 64'd1);
            void'(addr_q.pop_front());
            void'(data_q.pop_front());
            return;
        end
        a = addr_q.pop_front();
        chk("araddr", 64'(bus.m_araddr_o), 64'(a));
        chk("arprot", 64'(bus.m_arprot_o), 64'd0);
        for (int i = 0; i < ar_wait; i++) begin
            step();
            chk("ar_hold_vld", 64'(bus.m_arvalid_o), 64'd1);
            chk("ar_hold_addr", 64'(bus.m_araddr_o), 64'(a));
        end
        bus.m_arrdy_i = 1'b1;
        step();
        bus.m_arrdy_i = 1'b0;
        chk("ar_drop", 64'(bus.m_arvalid_o), 64'd0);
        chk("rrdy_up", 64'(bus.m_rrdy_o), 64'd1);
        for (int i = 0; i < r_wait; i++) begin
            step();
            chk("rrdy_hold", 64'(bus.m_rrdy_o), 64'd1);
            chk("no_early_strobe", 64'(pxl_vld), 64'd0);
        end
        bus.m_rdata_i  = d;
        bus.m_rresp_i  = resp;
        bus.m_rvalid_i = 1'b1;
        step();
        bus.m_rvalid_i = 1'b0;
        bus.m_rresp_i  = 2'b00;
        chk("strobe", 64'(pxl_vld), 64'd1);
        chk("pxl_data", pxl_data, data_q.pop_front());
        chk("rrdy_drop", 64'(bus.m_rrdy_o), 64'd0);
        step();
        chk("strobe_one_cycle", 64'(pxl_vld), 64'd0);
        chk("ar_count", 64'(ar_hs - hs0), 64'd1);
        chk("strobe_count", 64'(strobes - st0), 64'd1);
    endtask

    int hs0;
    int st0;
    int lat;
    bit seen;
    int blank_p[3] = '{700, 0, 640};
    int blank_l[3] = '{3, 480, 479};

    initial begin
        rst            = 1'b1;
        pxl            = 10'd700;
        line           = 10'd0;
        bus.m_arrdy_i  = 1'b0;
        bus.m_rvalid_i = 1'b0;
        bus.m_rdata_i  = '0;
        bus.m_rresp_i  = 2'b00;
        repeat (5) step();

        // Reset values
        chk("rst_arvalid", 64'(bus.m_arvalid_o), 64'd0);
        chk("rst_araddr", 64'(bus.m_araddr_o), 64'd0);
        chk("rst_arprot", 64'(bus.m_arprot_o), 64'd0);
        chk("rst_rrdy", 64'(bus.m_rrdy_o), 64'd0);
        chk("rst_pxl_vld", 64'(pxl_vld), 64'd0);
        chk("rst_pxl_data", pxl_data, 64'd0);
        chk("rst_rd_err", 64'(rd_err), 64'd0);

        rst = 1'b0;
        step();
        step();
        chk("blank_after_reset", 64'(bus.m_arvalid_o), 64'd0);

        // First fetch against a zero-wait slave: 3 cycles trigger to strobe
        addr_q.push_back(model_addr(0, 0));
        data_q.push_back(64'hDEAD_BEEF_0123_4567);
        hs0 = ar_hs;
        st0 = strobes;
        bus.m_arrdy_i  = 1'b1;
        bus.m_rvalid_i = 1'b1;
        bus.m_rdata_i  = 64'hDEAD_BEEF_0123_4567;
        pxl  = 10'd0;
        line = 10'd0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            lat++;
            if (bus.m_arvalid_o && addr_q.size() > 0) begin
                chk("first_araddr", 64'(bus.m_araddr_o), 64'(addr_q.pop_front()));
                chk("first_arprot", 64'(bus.m_arprot_o), 64'd0);
            end
            seen = pxl_vld;
        end
        chk("first_latency", 64'(lat), 64'd3);
        chk("first_data", pxl_data, data_q.pop_front());
        bus.m_arrdy_i  = 1'b0;
        bus.m_rvalid_i = 1'b0;
        repeat (3) step();
        chk("first_ar_count", 64'(ar_hs - hs0), 64'd1);
        chk("first_strobe_count", 64'(strobes - st0), 64'd1);
        chk("first_addr_seen", 64'(addr_q.size()), 64'd0);

        // Address math: pixel 5 of line 2 lives in word 321
        fetch(5, 2, 64'h1111_2222_3333_4444, 2'b00, 0, 0);
        hs0 = ar_hs;
        pxl = 10'd4; step(); step();
        pxl = 10'd6; step(); step();
        pxl = 10'd7; step(); step();
        chk("same_word_no_req", 64'(ar_hs - hs0), 64'd0);
        chk("same_word_arvalid", 64'(bus.m_arvalid_o), 64'd0);

        // Backpressure on both channels
        fetch(9, 2, 64'hA5A5_5A5A_0F0F_F0F0, 2'b00, 4, 3);

        // Error response is sticky across later OKAY beats
        fetch(0, 3, 64'hBAD0_BAD0_BAD0_BAD0, 2'b10, 0, 1);
        chk("err_set", 64'(rd_err), 64'd1);
        fetch(639, 479, 64'h0123_4567_89AB_CDEF, 2'b00, 1, 0);
        chk("err_sticky", 64'(rd_err), 64'd1);

        // Counters outside the visible window never request
        for (int k = 0; k < 3; k++) begin
            hs0  = ar_hs;
            pxl  = 10'(blank_p[k]);
            line = 10'(blank_l[k]);
            repeat (6) step();
            chk("blank_no_req", 64'(ar_hs - hs0), 64'd0);
            chk("blank_arvalid", 64'(bus.m_arvalid_o), 64'd0);
        end

        // Reset while an address is pending
        bus.m_arrdy_i = 1'b0;
        pxl  = 10'd0;
        line = 10'd10;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = bus.m_arvalid_o;
        end
        chk("pre_rst_arvalid", 64'(seen), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_drops_arvalid", 64'(bus.m_arvalid_o), 64'd0);
        chk("rst_clears_err", 64'(rd_err), 64'd0);
        chk("rst_clears_data", pxl_data, 64'd0);
        chk("rst_clears_addr", 64'(bus.m_araddr_o), 64'd0);
        repeat (2) step();
        rst = 1'b0;
        fetch(0, 10, 64'hCAFE_F00D_1234_5678, 2'b00, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_axi_mem_ctrl.md
Name: vga_axi_mem_ctrl

Overview:
AXI4-Lite read-only master that fetches frame-buffer words for the VGA pixel pipeline. It converts the current pixel/line counters into a word address and issues one AR/R transaction per new word. It presents each returned 64-bit word to the pixel path with a one-cycle valid strobe. It sits between the VGA timing generator and the system memory interconnect.

Parameters:
AXI_ADDR_WIDTH, 32, width of m_araddr_o.
AXI_DATA_WITH, 64, width of m_rdata_i and pxl_data_o (name spelling is fixed).
PXL_CTR_WIDTH, 10, width of pxl_ctr_i.
LINE_CTR_WIDTH, 10, width of line_ctr_i.
H_PIXELS, 640, visible pixels per line.
V_LINES, 480, visible lines per frame.
PXL_BITS, 16, bits per pixel. Must divide AXI_DATA_WITH; PPW = AXI_DATA_WITH/PXL_BITS = 4 pixels per word.
BASE_ADDR, 32'h0000_0000, byte address of pixel (0,0). Must be aligned to AXI_DATA_WITH/8.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
pxl_ctr_i  in  PXL_CTR_WIDTH  current horizontal pixel count.
line_ctr_i  in  LINE_CTR_WIDTH  current line count.
m_araddr_o  out  AXI_ADDR_WIDTH  AR address.
m_arprot_o  out  3  AR protection; constant 3'b000.
m_arvalid_o  out  1  AR valid.
m_arrdy_i  in  1  AR ready.
m_rdata_i  in  AXI_DATA_WITH  R data.
m_rvalid_i  in  1  R valid.
m_rrdy_o  out  1  R ready.
m_rresp_i  in  2  R response.
pxl_data_o  out  AXI_DATA_WITH  last fetched word.
pxl_data_valid_o  out  1  one-cycle strobe when pxl_data_o updates.
rd_err_o  out  1  sticky error flag, set on any non-OKAY response.

Behaviour:
- Reset: all outputs 0; state RESET; last_addr register set to all ones (no address matches it). The clock edge after rst deasserts moves the FSM to IDLE.
- Visible: pxl_ctr_i < H_PIXELS and line_ctr_i < V_LINES.
- Word address: BASE_ADDR + ((line_ctr_i*(H_PIXELS/PPW) + pxl_ctr_i/PPW) * (AXI_DATA_WITH/8)).
  - Computed combinationally, then truncated to AXI_ADDR_WIDTH.
  - Intermediate product must be wide enough for V_LINES*H_PIXELS with no overflow.
- States: RESET, IDLE, ADDR, DATA.
- IDLE:
  - If visible and word address != last_addr: latch the address into m_araddr_o and last_addr, set m_arvalid_o=1, go to ADDR next cycle.
  - Otherwise stay in IDLE.
- ADDR:
  - m_arvalid_o stays high and m_araddr_o stays stable until m_arvalid_o && m_arrdy_i on a rising edge.
  - On that edge: m_arvalid_o<=0, m_rrdy_o<=1, go to DATA.
  - Address is never withdrawn, even if the counters change meanwhile.
- DATA:
  - On m_rvalid_i && m_rrdy_o: pxl_data_o<=m_rdata_i, pxl_data_valid_o<=1 for exactly one cycle, m_rrdy_o<=0, go to IDLE.
  - If m_rresp_i != 2'b00 on that beat: set rd_err_o (cleared only by rst); data is still forwarded.
- At most one transaction outstanding. AR and R never overlap.
- Minimum cycle: IDLE trigger to data strobe is 3 cycles with zero-wait slave. Next request can start in the cycle after returning to IDLE.
- m_rvalid_i asserted while not in DATA is ignored (m_rrdy_o=0).
- rst asserted mid-transaction: immediate return to reset values. Any pending slave beat is abandoned.
- Counters leaving the visible area: no new requests; an in-flight transaction completes normally.
- New frame: if line 0 / pxl 0 matches last_addr (e.g. a single-word frame), no refetch. Normal frames always differ.

Test Plan:
- Reset: hold rst high 5 cycles -> all outputs 0, m_arvalid_o=0, rd_err_o=0. Release -> state IDLE within 1 cycle.
- First fetch: pxl=0, line=0, slave m_arrdy_i=1, then m_rvalid_i=1 with data 64'hDEAD_BEEF_0123_4567 -> m_araddr_o=0x0, m_arprot_o=0; one pxl_data_valid_o pulse with that data; exactly one AR handshake.
- Address math: pxl=5, line=2 -> m_araddr_o = (2*160+1)*8 = 0xA08. Pixels 4..7 on the same line produce no second request.
- Backpressure: m_arrdy_i low 4 cycles -> m_arvalid_o and m_araddr_o stable throughout. m_rvalid_i delayed 3 cycles -> m_rrdy_o held high, single strobe.
- Error response: m_rresp_i=2'b10 on the beat -> rd_err_o=1 and stays 1 over later OKAY beats until rst.
- Blanking/reset: pxl=700 -> no m_arvalid_o. rst asserted while in ADDR -> m_arvalid_o drops the same cycle. After release, the same address is re-requested.
